iter_divider: RTL and testbench
===============================

// Module: iter_divider
//
// PURPOSE
// Multi-cycle signed integer divider for the ALU execute path; the DIV-class sibling of the single-cycle compare logic.
// Each cycle it trial-subtracts the divisor from the partial remainder and uses the sign of that result as the
// "remainder < divisor" decision, producing one quotient bit per cycle.
// Sits beside the ALU, started by decode's DIV control pulse. Quotient and remainder go to the writeback mux,
// which stalls on div_busy.
//
// PARAMETERS
// WIDTH  32  operand, quotient and remainder width in bits (>= 4); all latencies below scale with it
//
// PORTS
// clock           in   1      single clock; all state updates on rising edge
// reset           in   1      asynchronous, active-high; clears all state and outputs immediately
// ctrl_DIV        in   1      start pulse; operands sampled on the same edge
// data_operandA   in   WIDTH  dividend, two's complement
// data_operandB   in   WIDTH  divisor, two's complement
// data_result     out  WIDTH  quotient, truncated toward zero
// data_remainder  out  WIDTH  remainder; sign equals dividend's sign, or zero
// data_exception  out  1      divide-by-zero flag for the completed operation
// data_resultRDY  out  1      one-cycle completion strobe
// div_busy        out  1      high while an operation is in flight
//
// BEHAVIOUR
// - Reset: every output is 0, the FSM is in IDLE and the counter is 0.
//   Asserting reset mid-operation aborts it; no RDY strobe is issued.
// - FSM has three states: IDLE, ITER, FIX.
//   - IDLE -> ITER on an edge that samples ctrl_DIV=1.
//   - ITER runs WIDTH edges, with count going 0..WIDTH-1. It moves to FIX on the edge where count == WIDTH-1.
//   - FIX -> IDLE after one edge.
// - Start edge (edge S):
//   - latch |A| into the quotient shift register and |B| into the divisor register;
//   - store sign_q = A[W-1]^B[W-1], sign_r = A[W-1], and div0 = (B==0);
//   - clear the partial remainder R (WIDTH+1 bits).
//   - Take absolute values with a two's-complement negate. |-2^(W-1)| is 2^(W-1) unsigned, which is correct.
// - ITER edge, restoring algorithm:
//   - shift {R,Q} left by 1;
//   - T = R_shifted - {0,divisor}, computed WIDTH+1 bits wide;
//   - if T[W] == 0, set R = T and Q[0] = 1; otherwise R is unchanged and Q[0] = 0.
// - FIX edge:
//   - data_result = sign_q ? -Q : Q, and data_remainder = sign_r ? -R : R, each truncated to WIDTH bits;
//   - data_exception = div0 and data_resultRDY = 1.
// - Latency: with ctrl_DIV sampled at edge S, data_resultRDY is high for exactly the cycle after edge S+WIDTH+1
//   (S+33 when WIDTH=32). It is low on every other cycle.
// - Output hold: data_result, data_remainder and data_exception hold their values until the next FIX edge or reset.
//   They are not cleared at start.
// - Divide by zero: the iteration still runs for the full latency.
//   - The FIX edge overrides the outputs to data_result = 0, data_remainder = dividend, data_exception = 1.
// - Overflow: -2^(W-1) / -1 yields data_result = 0x80000000 (wrap), data_remainder = 0, data_exception = 0.
// - div_busy is 1 from the edge after start through the FIX edge inclusive, and 0 in IDLE.
// - ctrl_DIV while busy: the current operation is abandoned with no strobe.
//   The new operands are latched on that edge, counting restarts at 0, and the FSM enters ITER.
//   This includes ctrl_DIV sampled on the FIX edge, whose strobe is suppressed.
// - ctrl_DIV held high for several cycles restarts on each sampled edge. Decode must pulse it for one cycle.
// - Operand inputs are ignored except on start edges.
//
// TESTING
// - 100 / 7: pulse ctrl_DIV at edge S.
//   Expect RDY only after edge S+33, result=14, remainder=2, exception=0; div_busy high during edges S+1..S+33.
// - Signs: -100/7 -> -14 rem -2; 100/-7 -> -14 rem 2; -100/-7 -> 14 rem -2.
//   Also 0x80000000/-1 -> 0x80000000 rem 0, exception 0.
// - Divide by zero: 1234/0 -> after 33 cycles result=0, remainder=1234, exception=1, single-cycle RDY.
//   A following 9/3 -> result 3, exception 0.
// - Restart: start 100/7, then pulse ctrl_DIV with 50/5 ten cycles later.
//   Expect no strobe for the first op, one strobe 33 cycles after the second start, result 10.
// - Reset mid-op: start 100/7 and assert reset asynchronously mid-cycle at iteration 12.
//   All outputs go 0 immediately and no strobe follows. The next op 0/5 returns 0 rem 0.
// - Back-to-back: pulse ctrl_DIV in the cycle right after RDY.
//   The second result is correct and its strobe appears 33 cycles later.

Source files
------------

// File: rtl/iter_divider.sv
// Multi-cycle signed restoring divider: one quotient bit per clock, sign fix-up on a final cycle.
// Quotient truncates toward zero; the remainder takes the dividend's sign.
module iter_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             div_busy
);

    // state  | meaning
    // S_IDLE | waiting for ctrl_DIV
    // S_ITER | one restoring step per edge, count 0..WIDTH-1
    // S_FIX  | apply signs, publish outputs, strobe RDY
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             div0_q, div0_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] a_abs, b_abs;
    logic [WIDTH:0]   rem_sh, trial;
    logic [WIDTH-1:0] quot_sh, quot_fix, rem_fix;

    // -2^(W-1) negates to itself, which read unsigned is the correct magnitude
    assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    // The partial remainder never reaches the divisor, so its top bit is always 0 and is not stored
    assign rem_sh  = {rem_q, quot_q[WIDTH-1]};
    assign quot_sh = {quot_q[WIDTH-2:0], 1'b0};
    assign trial   = rem_sh - {1'b0, dvsr_q};

    assign quot_fix = neg_quot_q ? -quot_q : quot_q;
    assign rem_fix  = neg_rem_q  ? -rem_q  : rem_q;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        dvsr_d      = dvsr_q;
        neg_quot_d  = neg_quot_q;
        neg_rem_d   = neg_rem_q;
        div0_d      = div0_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;

        if (ctrl_DIV) begin
            // A start in any state abandons whatever is in flight
            state_d    = S_ITER;
            count_d    = '0;
            quot_d     = a_abs;
            dvsr_d     = b_abs;
            rem_d      = '0;
            neg_quot_d = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            neg_rem_d  = data_operandA[WIDTH-1];
            div0_d     = (data_operandB == '0);
        end else begin
            unique case (state_q)
                S_ITER: begin
                    if (!trial[WIDTH]) begin
                        rem_d  = trial[WIDTH-1:0];
                        quot_d = quot_sh | {{(WIDTH-1){1'b0}}, 1'b1};
                    end else begin
                        rem_d  = rem_sh[WIDTH-1:0];
                        quot_d = quot_sh;
                    end
                    if (count_q == LAST) begin
                        state_d = S_FIX;
                        count_d = '0;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                S_FIX: begin
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
                    exc_d   = div0_q;
                    // With a zero divisor every trial succeeds, leaving |A| in R, so rem_fix is the dividend
                    result_d    = div0_q ? '0 : quot_fix;
                    remainder_d = rem_fix;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            dvsr_q      <= '0;
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
            div0_q      <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            dvsr_q      <= dvsr_d;
            neg_quot_q  <= neg_quot_d;
            neg_rem_q   <= neg_rem_d;
            div0_q      <= div0_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign div_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: signed cases, divide-by-zero, restart, mid-op reset, back-to-back.
module tb_iter_divider;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         ctrl_DIV = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [W-1:0] data_result;
    logic [W-1:0] data_remainder;
    logic         data_exception;
    logic         data_resultRDY;
    logic         div_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_cnt;

    always #5 clock = ~clock;

    iter_divider #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (data_result),
        .data_remainder (data_remainder),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .div_busy       (div_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the following posedge is the start edge S
    task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
        ctrl_DIV = 1'b1;
        op_a     = a;
        op_b     = b;
        @(negedge clock);
        ctrl_DIV = 1'b0;
        op_a     = 32'hDEAD_BEEF;
        op_b     = 32'h0BAD_F00D;
    endtask

    // Entered at the negedge after edge S (j=0); j counts edges since S
    task automatic wait_done(input string tag);
        int lat = -1;
        int busy_gaps = 0;
        for (int j = 0; j <= LAT + 8 && lat < 0; j++) begin
            if (j > 0) @(negedge clock);
            if (data_resultRDY) lat = j;
            else if (!div_busy) busy_gaps++;
        end
        check({tag, "_latency"}, lat, LAT);
        check({tag, "_busy_gap"}, busy_gaps, 0);
        check({tag, "_busy_end"}, {31'd0, div_busy}, 32'd0);
        @(negedge clock);
        check({tag, "_rdy_width"}, {31'd0, data_resultRDY}, 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input logic ee);
        pulse_start(a, b);
        wait_done(tag);
        check({tag, "_quot"}, data_result, eq);
        check({tag, "_rem"}, data_remainder, er);
        check({tag, "_exc"}, {31'd0, data_exception}, {31'd0, ee});
    endtask

    initial begin
        #1;
        check("rst_quot", data_result, 32'd0);
        check("rst_rem", data_remainder, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        run_op("p100_7",   100,  7, 14, 2, 1'b0);
        run_op("n100_7",  -100,  7, -14, -2, 1'b0);
        run_op("p100_n7",  100, -7, -14, 2, 1'b0);
        run_op("n100_n7", -100, -7, 14, -2, 1'b0);
        run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        run_op("div0", 1234, 0, 0, 1234, 1'b1);
        run_op("after_div0", 9, 3, 3, 0, 1'b0);
        run_op("neg_div0", -5, 0, 0, -5, 1'b1);

        // Restart ten edges into an operation
        pulse_start(100, 7);
        rdy_cnt = 0;
        repeat (9) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        pulse_start(50, 5);
        wait_done("restart");
        check("restart_first_rdy", rdy_cnt, 0);
        check("restart_quot", data_result, 10);
        check("restart_rem", data_remainder, 0);

        // Restart sampled on the FIX edge suppresses that strobe
        pulse_start(7, 2);
        rdy_cnt = 0;
        repeat (32) begin
            @(negedge clock);
            if (data_resultRDY) rdy_cnt++;
        end
        pulse_start(-7, 2);
        wait_done("fix_restart");
        check("fix_restart_first_rdy", rdy_cnt, 0);
        check("fix_restart_quot", data_result, -3);
        check("fix_restart_rem", data_remainder, -1);

        // Asynchronous reset mid-operation
        pulse_start(100, 7);
        repeat (12) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        check("midrst_quot", data_result, 32'd0);
        check("midrst_rem", data_remainder, 32'd0);
        check("midrst_busy", {31'd0, div_busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        rdy_cnt = 0;
        repeat (LAT + 8) begin
            @(negedge clock);
            if (data_resultRDY || div_busy) rdy_cnt++;
        end
        check("midrst_no_strobe", rdy_cnt, 0);
        run_op("after_rst", 0, 5, 0, 0, 1'b0);

        // Back-to-back: starts in the cycle right after the previous strobe
        run_op("b2b_a", 7, -2, -3, 1, 1'b0);
        run_op("b2b_b", 1000, 10, 100, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
